// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage: pipelined SRAM-like fetch with a
// PC queue, an instruction buffer and cancel-on-redirect.
`timescale 1ns/1ps
module if_prefetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          N_REDIR         = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic                   inst_sram_req,
  output logic                   inst_sram_wr,
  output logic [1:0]             inst_sram_size,
  output logic [3:0]             inst_sram_wstrb,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic                   inst_sram_addr_ok,
  input  logic                   inst_sram_data_ok,
  input  logic [31:0]            inst_sram_rdata,
  input  logic [N_REDIR-1:0]     redir_valid,
  input  logic [32*N_REDIR-1:0]  redir_target,
  input  logic                   id_allowin,
  output logic                   if_to_id_valid,
  output logic [31:0]            if_inst,
  output logic [31:0]            if_pc,
  output logic                   if_exc_adef
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW  = (MAX_OUTSTANDING > 1) ?
                       $clog2(MAX_OUTSTANDING) : 1;
  localparam int BW  = $clog2(IBUF_DEPTH);
  localparam int BCW = BW + 1;
  localparam int SW  = BCW + 1;

  localparam logic [CW-1:0]  MAX_C   = CW'(MAX_OUTSTANDING);
  localparam logic [QW-1:0]  Q_LAST  = QW'(MAX_OUTSTANDING - 1);
  localparam logic [BCW-1:0] DEPTH_C = BCW'(IBUF_DEPTH);
  localparam logic [SW-1:0]  DEPTH_S = SW'(IBUF_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } ibuf_t;

  logic [31:0]    fetch_pc;
  logic [CW-1:0]  total;
  logic [CW-1:0]  cancel;
  logic [CW-1:0]  live;
  logic           halt;

  logic [31:0]    pcq [MAX_OUTSTANDING];
  logic [QW-1:0]  pcq_wr;
  logic [QW-1:0]  pcq_rd;

  ibuf_t          ibuf [IBUF_DEPTH];
  logic [BW-1:0]  buf_wr;
  logic [BW-1:0]  buf_rd;
  logic [BCW-1:0] buf_cnt;
  logic           buf_empty;

  logic           redir;
  logic [31:0]    redir_pc;
  logic           aligned;
  logic           room;
  logic           acc;
  logic           dok;
  logic           drop;
  logic           push_data;
  logic           push_adef;
  logic           push;
  logic           pop;
  ibuf_t          push_ent;
  ibuf_t          head;

  assign redir     = |redir_valid;
  assign live      = total - cancel;
  assign aligned   = fetch_pc[1:0] == 2'b00;
  assign buf_empty = buf_cnt == '0;
  assign room      = (SW'(buf_cnt) + SW'(live)) < DEPTH_S;

  assign inst_sram_req   = resetn & ~redir & ~halt & aligned &
                           (total < MAX_C) & room;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_addr  = fetch_pc;
  assign inst_sram_wdata = 32'h0;

  assign acc       = inst_sram_req & inst_sram_addr_ok;
  assign dok       = inst_sram_data_ok;
  assign drop      = cancel != '0;
  assign push_data = dok & ~drop & ~redir;
  assign push_adef = ~redir & ~halt & ~aligned &
                     (total == '0) & (buf_cnt < DEPTH_C);
  assign push      = push_data | push_adef;

  assign head           = ibuf[buf_rd];
  assign if_to_id_valid = ~buf_empty & ~redir;
  assign pop            = if_to_id_valid & id_allowin;
  assign if_pc          = buf_empty ? 32'h0 : head.pc;
  assign if_inst        = buf_empty ? 32'h0 : head.inst;
  assign if_exc_adef    = ~buf_empty & head.exc;

  // Lowest-index redirect channel wins.
  always_comb begin
    redir_pc = 32'h0;
    for (int i = N_REDIR - 1; i >= 0; i--)
      if (redir_valid[i]) redir_pc = redir_target[32*i +: 32];
  end

  // Entry written into the buffer: bus data or fetch fault.
  always_comb begin
    push_ent = '{pc: pcq[pcq_rd], inst: inst_sram_rdata,
                 exc: 1'b0};
    if (push_adef)
      push_ent = '{pc: fetch_pc, inst: 32'h0, exc: 1'b1};
  end

  // Fetch PC, outstanding/discard counters and fault halt.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc <= RESET_PC;
      total    <= '0;
      cancel   <= '0;
      halt     <= 1'b0;
    end else begin
      total <= total + CW'(acc) - CW'(dok);
      if (redir) begin
        fetch_pc <= redir_pc;
        cancel   <= cancel + live - CW'(dok);
        halt     <= 1'b0;
      end else begin
        if (acc) fetch_pc <= fetch_pc + 32'd4;
        if (dok && drop) cancel <= cancel - CW'(1);
        if (push_adef) halt <= 1'b1;
      end
    end
  end

  // In-flight PC queue, popped only by live responses.
  always_ff @(posedge clk) begin
    if (!resetn || redir) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else begin
      if (acc) begin
        pcq[pcq_wr] <= fetch_pc;
        pcq_wr <= (pcq_wr == Q_LAST) ? '0 : pcq_wr + QW'(1);
      end
      if (push_data)
        pcq_rd <= (pcq_rd == Q_LAST) ? '0 : pcq_rd + QW'(1);
    end
  end

  // Instruction buffer toward ID; flushed on redirect.
  always_ff @(posedge clk) begin
    if (!resetn || redir) begin
      buf_wr  <= '0;
      buf_rd  <= '0;
      buf_cnt <= '0;
    end else begin
      if (push) begin
        ibuf[buf_wr] <= push_ent;
        buf_wr <= buf_wr + BW'(1);
      end
      if (pop) buf_rd <= buf_rd + BW'(1);
      buf_cnt <= buf_cnt + BCW'(push) - BCW'(pop);
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: vector table for streaming and
// stall, directed sequences for redirect corner cases.
`timescale 1ns/1ps
module tb_if_prefetch_stage;

  localparam logic [31:0] B = 32'h1c000000;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         inst_sram_req;
  logic         inst_sram_wr;
  logic [1:0]   inst_sram_size;
  logic [3:0]   inst_sram_wstrb;
  logic [31:0]  inst_sram_addr;
  logic [31:0]  inst_sram_wdata;
  logic         inst_sram_addr_ok;
  logic         inst_sram_data_ok;
  logic [31:0]  inst_sram_rdata;
  logic [4:0]   redir_valid = '0;
  logic [159:0] redir_target = '0;
  logic         id_allowin = 1'b0;
  logic         if_to_id_valid;
  logic [31:0]  if_inst;
  logic [31:0]  if_pc;
  logic         if_exc_adef;

  int checks = 0;
  int failures = 0;
  logic resp_en = 1'b1;
  logic [31:0] bq [$];

  if_prefetch_stage dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req),
    .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .redir_valid(redir_valid),
    .redir_target(redir_target),
    .id_allowin(id_allowin),
    .if_to_id_valid(if_to_id_valid),
    .if_inst(if_inst), .if_pc(if_pc),
    .if_exc_adef(if_exc_adef)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16] ^ 16'h0ff0};
  endfunction

  // Bus: accepts every request, answers in order one cycle later.
  assign inst_sram_addr_ok = inst_sram_req;

  always @(posedge clk) begin
    if (!resetn) begin
      bq.delete();
      inst_sram_data_ok <= 1'b0;
      inst_sram_rdata <= 32'h0;
    end else begin
      if (inst_sram_data_ok) void'(bq.pop_front());
      if (inst_sram_req && inst_sram_addr_ok)
        bq.push_back(inst_sram_addr);
      if (resp_en && bq.size() > 0) begin
        inst_sram_data_ok <= 1'b1;
        inst_sram_rdata <= rd_fn(bq[0]);
      end else begin
        inst_sram_data_ok <= 1'b0;
      end
    end
  end

  // A response with nothing outstanding is a bus error.
  always @(negedge clk) begin
    if (resetn && inst_sram_data_ok && dut.total == '0) begin
      failures++;
      $display("FAIL bus_err data_ok with total=0 t=%0t", $time);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_tgt(input int ch, input logic [31:0] v);
    redir_target[32*ch +: 32] = v;
  endtask

  task automatic do_reset();
    step();
    resetn = 1'b0;
    redir_valid = '0;
    id_allowin = 1'b0;
    step();
    samp();
    chk("rst_req", {31'b0, inst_sram_req}, 32'd0);
    chk("rst_valid", {31'b0, if_to_id_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_adef", {31'b0, if_exc_adef}, 32'd0);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!if_to_id_valid && n < 30) begin
      step();
      samp();
      n++;
    end
    if (!if_to_id_valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for valid", nm);
    end
  endtask

  typedef struct {
    logic        allow;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic al, input logic rq,
                     input logic [31:0] ad, input logic vl,
                     input logic [31:0] pc);
    vec_t v;
    v.allow = al;
    v.exp_req = rq;
    v.exp_addr = B + ad;
    v.exp_valid = vl;
    v.exp_pc = B + pc;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    add(1, 1, 'h00, 0, 'h00);
    add(1, 1, 'h04, 0, 'h00);
    add(1, 1, 'h08, 1, 'h00);
    add(1, 1, 'h0c, 1, 'h04);
    add(1, 1, 'h10, 1, 'h08);
    add(0, 1, 'h14, 1, 'h0c);
    add(0, 1, 'h18, 1, 'h0c);
    for (int i = 0; i < 8; i++) add(0, 0, 'h00, 1, 'h0c);
    add(1, 0, 'h00, 1, 'h0c);
    add(1, 1, 'h1c, 1, 'h10);
    add(1, 1, 'h20, 1, 'h14);
    add(1, 1, 'h24, 1, 'h18);
    add(1, 1, 'h28, 1, 'h1c);
    add(1, 1, 'h2c, 1, 'h20);
    add(1, 1, 'h30, 1, 'h24);

    // Streaming from reset, then a 10-cycle ID stall.
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      step();
      resetn = 1'b1;
      id_allowin = vecs[i].allow;
      samp();
      chk($sformatf("v%0d_req", i), {31'b0, inst_sram_req},
          {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        chk($sformatf("v%0d_addr", i), inst_sram_addr,
            vecs[i].exp_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, if_to_id_valid},
          {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_pc", i), if_pc, vecs[i].exp_pc);
        chk($sformatf("v%0d_inst", i), if_inst,
            rd_fn(vecs[i].exp_pc));
        chk($sformatf("v%0d_adef", i), {31'b0, if_exc_adef},
            32'd0);
      end
    end

    // Two requests held on the bus, then a redirect.
    resp_en = 1'b0;
    do_reset();
    step();
    resetn = 1'b1;
    id_allowin = 1'b1;
    samp();
    chk("a_req0", inst_sram_addr, B);
    step();
    samp();
    chk("a_req1", inst_sram_addr, B + 32'h4);
    step();
    set_tgt(3, B + 32'h100);
    redir_valid = 5'b01000;
    samp();
    chk("a_total", 32'(dut.total), 32'd2);
    chk("a_redir_valid", {31'b0, if_to_id_valid}, 32'd0);
    step();
    redir_valid = '0;
    resp_en = 1'b1;
    samp();
    chk("a_cancel2", 32'(dut.cancel), 32'd2);
    chk("a_req_blocked", {31'b0, inst_sram_req}, 32'd0);
    wait_valid("a_first");
    chk("a_first_pc", if_pc, B + 32'h100);
    chk("a_first_inst", if_inst, rd_fn(B + 32'h100));
    chk("a_cancel0", 32'(dut.cancel), 32'd0);

    // Two channels at once: the lower index wins.
    do_reset();
    step();
    resetn = 1'b1;
    id_allowin = 1'b1;
    samp();
    repeat (4) begin step(); samp(); end
    step();
    set_tgt(1, B + 32'h200);
    set_tgt(3, B + 32'h300);
    redir_valid = 5'b01010;
    samp();
    chk("b_valid_redir", {31'b0, if_to_id_valid}, 32'd0);
    chk("b_req_redir", {31'b0, inst_sram_req}, 32'd0);
    step();
    redir_valid = '0;
    samp();
    chk("b_req_next", inst_sram_addr, B + 32'h200);
    wait_valid("b_first");
    chk("b_first_pc", if_pc, B + 32'h200);
    chk("b_first_inst", if_inst, rd_fn(B + 32'h200));
    step();
    samp();
    chk("b_second_pc", if_pc, B + 32'h204);

    // Misaligned target: one fault entry, then halted.
    do_reset();
    step();
    resetn = 1'b1;
    id_allowin = 1'b1;
    samp();
    repeat (3) begin step(); samp(); end
    step();
    set_tgt(0, B + 32'h102);
    redir_valid = 5'b00001;
    samp();
    step();
    redir_valid = '0;
    samp();
    wait_valid("c_adef");
    chk("c_adef_pc", if_pc, B + 32'h102);
    chk("c_adef_inst", if_inst, 32'h0);
    chk("c_adef_flag", {31'b0, if_exc_adef}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      samp();
      chk($sformatf("c_halt_req%0d", i),
          {31'b0, inst_sram_req}, 32'd0);
      chk($sformatf("c_halt_valid%0d", i),
          {31'b0, if_to_id_valid}, 32'd0);
    end
    step();
    set_tgt(4, B + 32'h400);
    redir_valid = 5'b10000;
    samp();
    step();
    redir_valid = '0;
    samp();
    chk("c_resume_req", {31'b0, inst_sram_req}, 32'd1);
    chk("c_resume_addr", inst_sram_addr, B + 32'h400);

    // Redirect with data_ok and pop while the buffer is full.
    do_reset();
    step();
    resetn = 1'b1;
    id_allowin = 1'b0;
    samp();
    repeat (3) begin step(); samp(); end
    step();
    set_tgt(2, B + 32'h500);
    redir_valid = 5'b00100;
    id_allowin = 1'b1;
    samp();
    chk("d_pre_cnt", 32'(dut.buf_cnt), 32'd3);
    chk("d_pre_live", 32'(dut.total - dut.cancel), 32'd1);
    chk("d_valid_redir", {31'b0, if_to_id_valid}, 32'd0);
    step();
    redir_valid = '0;
    samp();
    chk("d_cnt", 32'(dut.buf_cnt), 32'd0);
    chk("d_cancel", 32'(dut.cancel), 32'd0);
    chk("d_total", 32'(dut.total), 32'd0);
    chk("d_valid", {31'b0, if_to_id_valid}, 32'd0);
    chk("d_req_addr", inst_sram_addr, B + 32'h500);
    wait_valid("d_first");
    chk("d_first_pc", if_pc, B + 32'h500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
